// File: rtl/clb_bist_top_pkg.sv
// Shared constants for the CLB built-in self-test wrapper: defaults,
// LFSR feedback taps and the CLB mode encoding.
package clb_bist_top_pkg;

    localparam logic [15:0] LUT_INIT_DEF  = 16'h6996;
    localparam logic [3:0]  LFSR_SEED_DEF = 4'b0001;

    // Feedback taps for x^4+x^3+1
    localparam int LFSR_TAP_HI = 3;
    localparam int LFSR_TAP_LO = 2;

    typedef enum logic {
        MODE_LOGIC = 1'b0,
        MODE_ARITH = 1'b1
    } mode_t;

endpackage

// File: rtl/clb_bist_top_if.sv
// Pattern/control bus between the test harness and the CLB BIST wrapper.
interface clb_bist_top_if;

    logic       tm;
    logic       hold;
    logic       sa1;
    logic       sa0;
    logic [3:0] in;
    logic       out;
    logic       pass;
    logic       fail;
    logic       done;

    modport master (output tm, hold, sa1, sa0, in, input out, pass, fail, done);
    modport slave  (input tm, hold, sa1, sa0, in, output out, pass, fail, done);

endinterface

// File: rtl/clb_bist_top_clb.sv
// 4-input CLB with registered sum/LUT output and carry. The force inputs
// let a wrapper override the x register input; the golden copy ties them off.
module clb
    import clb_bist_top_pkg::*;
#(
    parameter logic [15:0] LUT_INIT = LUT_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] z,
    input  mode_t      m,
    input  logic       cin,
    input  logic       force_en,
    input  logic       force_val,
    output logic       x,
    output logic       c
);

    logic [2:0] sum;
    logic       x_next;
    logic       c_next;

    always_comb begin
        sum    = {1'b0, z[1:0]} + {1'b0, z[3:2]} + {2'b00, cin};
        x_next = LUT_INIT[z];
        c_next = 1'b0;
        if (m == MODE_ARITH) begin
            x_next = sum[0];
            c_next = sum[2];
        end
        if (force_en) begin
            x_next = force_val;
        end
    end

    // Stage boundary: CLB output register
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= 1'b0;
            c <= 1'b0;
        end else begin
            x <= x_next;
            c <= c_next;
        end
    end

endmodule

// File: rtl/clb_bist_top_induced.sv
// Fault-injectable CLB copy: stuck-at-1 wins over stuck-at-0 at the x register.
module induced
    import clb_bist_top_pkg::*;
#(
    parameter logic [15:0] LUT_INIT = LUT_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] z,
    input  mode_t      m,
    input  logic       cin,
    input  logic       sa1,
    input  logic       sa0,
    output logic       x,
    output logic       c
);

    clb #(.LUT_INIT(LUT_INIT)) u_clb (
        .clk       (clk),
        .rst       (rst),
        .z         (z),
        .m         (m),
        .cin       (cin),
        .force_en  (sa1 | sa0),
        .force_val (sa1),
        .x         (x),
        .c         (c)
    );

endmodule

// File: rtl/clb_bist_top_lfsr1.sv
// 4-bit Fibonacci LFSR, period 15, free-running from a nonzero seed.
module lfsr1
    import clb_bist_top_pkg::*;
#(
    parameter logic [3:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/clb_bist_top.sv
// BIST wrapper: LFSR or external operand feeds a golden and a faulty CLB,
// and a registered comparator flags agreement while in test mode.
module clb_bist_top
    import clb_bist_top_pkg::*;
#(
    parameter logic [15:0] LUT_INIT  = LUT_INIT_DEF,
    parameter logic [3:0]  LFSR_SEED = LFSR_SEED_DEF
) (
    input logic           clk,
    input logic           rst,
    clb_bist_top_if.slave bus
);

    logic [3:0] lfsr_q;
    logic [3:0] z_p0;
    mode_t      m_p0;
    logic       cin_p0;
    logic       x1_p1;
    logic       x2_p1;
    logic       c1_p1;
    logic       c2_p1;
    logic       pass_p2;
    logic       fail_p2;
    logic       unused_c2;

    lfsr1 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Stage boundary: operand and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            z_p0   <= 4'b0000;
            m_p0   <= MODE_LOGIC;
            cin_p0 <= 1'b0;
        end else begin
            z_p0   <= bus.tm ? lfsr_q : bus.in;
            m_p0   <= bus.hold ? MODE_LOGIC : MODE_ARITH;
            cin_p0 <= 1'b0;
        end
    end

    clb #(.LUT_INIT(LUT_INIT)) u_golden (
        .clk       (clk),
        .rst       (rst),
        .z         (z_p0),
        .m         (m_p0),
        .cin       (cin_p0),
        .force_en  (1'b0),
        .force_val (1'b0),
        .x         (x1_p1),
        .c         (c1_p1)
    );

    induced #(.LUT_INIT(LUT_INIT)) u_induced (
        .clk (clk),
        .rst (rst),
        .z   (z_p0),
        .m   (m_p0),
        .cin (cin_p0),
        .sa1 (bus.sa1),
        .sa0 (bus.sa0),
        .x   (x2_p1),
        .c   (c2_p1)
    );

    // Stage boundary: comparator register
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_p2 <= 1'b0;
            fail_p2 <= 1'b0;
        end else begin
            pass_p2 <= bus.tm & (x1_p1 == x2_p1);
            fail_p2 <= bus.tm & (x1_p1 != x2_p1);
        end
    end

    // Carries are kept for observability only; neither copy's carry is compared
    assign unused_c2 = c2_p1;

    assign bus.out  = x2_p1;
    assign bus.pass = pass_p2;
    assign bus.fail = fail_p2;
    assign bus.done = pass_p2;

endmodule

// File: tb/tb_clb_bist_top.sv
// Directed bench for clb_bist_top with a cycle model feeding an expected-value queue.
module tb_clb_bist_top;

    typedef struct {
        logic       out;
        logic       pass;
        logic       fail;
        logic       done;
        logic       c1;
        logic [3:0] z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clb_bist_top_if bus ();

    clb_bist_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                             4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                             4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    int         idx;
    logic [3:0] mz;
    logic       mm, mx1, mx2, mc1, mpass, mfail;

    function automatic logic ref_clb(input logic [3:0] z, input logic arith, output logic c);
        int s;
        if (arith) begin
            s = int'(z[1:0]) + int'(z[3:2]);
            c = (s >= 4);
            return (s % 2) == 1;
        end
        c = 1'b0;
        return ^z;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic h,
                        input logic s1, input logic s0, input logic [3:0] i);
        exp_t e;
        logic nx, nc;
        rst      = r;
        bus.tm   = t;
        bus.hold = h;
        bus.sa1  = s1;
        bus.sa0  = s0;
        bus.in   = i;
        if (r) begin
            idx = 0; mz = 4'b0000; mm = 1'b0;
            mx1 = 1'b0; mx2 = 1'b0; mc1 = 1'b0; mpass = 1'b0; mfail = 1'b0;
        end else begin
            nx    = ref_clb(mz, mm, nc);
            mpass = t & (mx1 == mx2);
            mfail = t & (mx1 != mx2);
            mx1   = nx;
            mc1   = nc;
            mx2   = s1 ? 1'b1 : (s0 ? 1'b0 : nx);
            mm    = ~h;
            mz    = t ? seq[idx] : i;
            idx   = (idx + 1) % 15;
        end
        e.out = mx2; e.pass = mpass; e.fail = mfail; e.done = mpass; e.c1 = mc1; e.z = mz;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out",  {3'b000, bus.out},     {3'b000, e.out});
        chk("pass", {3'b000, bus.pass},    {3'b000, e.pass});
        chk("fail", {3'b000, bus.fail},    {3'b000, e.fail});
        chk("done", {3'b000, bus.done},    {3'b000, e.done});
        chk("c1",   {3'b000, dut.c1_p1},   {3'b000, e.c1});
        chk("z",    dut.z_p0,              e.z);
    endtask

    initial begin
        rst = 1'b1;
        bus.tm = 1'b1; bus.hold = 1'b1; bus.sa1 = 1'b0; bus.sa0 = 1'b0; bus.in = 4'b0000;

        // Reset, then LFSR run with no faults
        step(1, 1, 1, 0, 0, 4'b0000);
        step(1, 1, 1, 0, 0, 4'b0000);
        for (int k = 0; k < 32; k++) step(0, 1, 1, 0, 0, 4'b0000);

        // Stuck-at-0 sweep
        for (int k = 0; k < 17; k++) step(0, 1, 1, 0, 1, 4'b0000);

        // Stuck-at-1 sweep, then both faults asserted
        for (int k = 0; k < 17; k++) step(0, 1, 1, 1, 0, 4'b0000);
        for (int k = 0; k < 17; k++) step(0, 1, 1, 1, 1, 4'b0000);

        // Functional logic mode
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 4'b0111);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 4'b1001);

        // Functional arithmetic mode
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 4'b0011);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 4'b1011);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 4'b0101);

        // Mid-run reset with a fault active, then restart
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 1, 4'b0000);
        step(1, 1, 1, 1, 0, 4'b0000);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 1, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
